uart_tx_fsm: RTL

//   Frame controller for the UART transmitter. It accepts a parallel byte,

---
 rtl/uart_tx_fsm.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: UART transmit frame controller.
// Accepts a parallel byte while idle, pulses the serializer load, sequences
// the serializer shift enable and drives the TX line mux:
// start bit, FRAME_WIDTH data bits (LSB first), optional parity, stop bit.
// Optional feature: define UART_TX_PARITY_EN to build the parity state and
// parity register; otherwise par_en/par_typ are ignored and every frame
// is FRAME_WIDTH+2 cycles long.
module uart_tx_fsm #(
  parameter int unsigned FRAME_WIDTH   = 8,
  parameter int unsigned COUNTER_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Data_Valid,
  input  logic [FRAME_WIDTH-1:0] P_Data,
  input  logic                   par_en,
  input  logic                   par_typ,
  input  logic                   ser_data,
  output logic                   ser_load,
  output logic                   ser_en,
  output logic                   busy,
  output logic                   TX_OUT
);

  localparam logic [COUNTER_WIDTH-1:0] LAST_BIT = COUNTER_WIDTH'(FRAME_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

  state_t                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic parity_q, parity_d;
`else
  // Inputs only consumed by the parity feature are left unused here.
  logic unused_parity_inputs;
  assign unused_parity_inputs = ^{P_Data, par_en, par_typ};
`endif

  // Serializer load is only allowed while idle so a frame's byte is never overwritten.
  assign ser_load = Data_Valid & (state_q == IDLE);
  assign busy     = (state_q != IDLE);

  // State, bit counter and latched parity configuration registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
`ifdef UART_TX_PARITY_EN
      par_en_q <= par_en_d;
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state, counter update and line/shift-enable decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ser_en   = 1'b0;
    TX_OUT   = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_en_d = par_en_q;
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          state_d  = START;
`ifdef UART_TX_PARITY_EN
          par_en_d = par_en;
          parity_d = (^P_Data) ^ par_typ;
`endif
        end
      end
      START: begin
        TX_OUT  = 1'b0;
        ser_en  = 1'b1;
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        // The START pulse plus FRAME_WIDTH-1 pulses here give FRAME_WIDTH shifts,
        // so the last data cycle must not shift.
        TX_OUT = ser_data;
        ser_en = (cnt_q < LAST_BIT);
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          state_d = par_en_q ? PARITY : STOP;
`else
          state_d = STOP;
`endif
        end else begin
          cnt_d = cnt_q + COUNTER_WIDTH'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        TX_OUT  = parity_q;
        state_d = STOP;
      end
`endif
      STOP: begin
        TX_OUT  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
